// File: rtl/mio_pkg.sv
// mio_pkg: shared MIO bus constants for the keyboard IO window and PS/2 framing.
package mio_pkg;
  localparam logic [31:0] IO_BASE = 32'ha000_0000;
  localparam logic [2:0] IO_MASK = 3'b101;
  localparam int PS2_FRAME_BITS = 11;
  localparam int KBD_READY_BIT = 8;
  localparam int KBD_DATA_MSB = 7;
  // f[0]=start, f[8:1]=data, f[9]=odd parity, f[10]=stop
  function automatic logic frame_ok(input logic [10:0] f);
    return ~f[0] & f[10] & (^f[9:1]);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two FIFO with extra pointer MSB to tell full from empty.
module sync_fifo #(
  parameter int AW = 3,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         wr,
  input  logic         rd,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  logic [W-1:0] mem [2**AW];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign head = empty ? '0 : mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd && !empty) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 frame receiver with timeout, buffering valid scan codes
// in a FIFO that the MIO bus pops with falling edges of io_rdn.
module ps2_keyboard
  import mio_pkg::*;
#(
  parameter int FIFO_AW = 3,
  parameter int TIMEOUT_CYC = 2500
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       io_rdn,
  output logic [7:0] key_data,
  output logic       ready,
  output logic       overflow
);
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  logic [2:0] c_s;
  logic [1:0] d_s;
  logic [3:0] cnt;
  logic [IW-1:0] idle;
  logic [9:0] sh;
  logic rd_prev, fall, done, valid, pop, wr, full, empty;
  assign fall = c_s[2] & ~c_s[1];
  assign done = fall && cnt == 4'(PS2_FRAME_BITS - 1);
  assign valid = done && frame_ok({d_s[1], sh});
  assign pop = rd_prev & ~io_rdn & ~empty;
  // A full FIFO still accepts a frame when the bus frees a slot this cycle.
  assign wr = valid & (~full | pop);
  assign ready = ~empty;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      c_s <= '1;
      d_s <= '1;
      rd_prev <= 1'b1;
      cnt <= '0;
      idle <= '0;
      sh <= '0;
      overflow <= 1'b0;
    end else begin
      c_s <= {c_s[1:0], ps2_clk};
      d_s <= {d_s[0], ps2_data};
      rd_prev <= io_rdn;
      if (fall) begin
        sh <= {d_s[1], sh[9:1]};
        cnt <= done ? 4'd0 : cnt + 4'd1;
        idle <= '0;
      end else if (cnt == 4'd0) begin
        idle <= '0;
      end else if (idle == IW'(TIMEOUT_CYC)) begin
        cnt <= '0;
        idle <= '0;
      end else begin
        idle <= idle + 1'b1;
      end
      if (pop) overflow <= 1'b0;
      else if (valid && full) overflow <= 1'b1;
    end
  sync_fifo #(.AW(FIFO_AW), .W(8)) u_fifo (
    .clk(clk),
    .clrn(clrn),
    .wr(wr),
    .rd(pop),
    .din(sh[8:1]),
    .full(full),
    .empty(empty),
    .head(key_data)
  );
endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: directed and random PS/2 traffic against a queue-based
// model of the keyboard FIFO and overflow flag.
module tb_ps2_keyboard;
  localparam int HP = 4;
  logic clk = 0, clrn = 0, ps2_clk = 1, ps2_data = 1, io_rdn = 1;
  logic [7:0] key_data;
  logic ready, overflow;
  int checks = 0, errors = 0;
  byte unsigned q[$];
  bit m_ov = 0;

  ps2_keyboard dut (
    .clk(clk),
    .clrn(clrn),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .io_rdn(io_rdn),
    .key_data(key_data),
    .ready(ready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk(input byte unsigned d, input bit bp, input bit bs, input bit bst);
    return {~bs, (~^d) ^ bp, d, bst};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n, input bit rd_sync);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      tick(HP);
      ps2_clk = 0;
      if (rd_sync && i == n - 1) begin
        tick(2);
        io_rdn = 0;
        tick(HP - 2);
      end else tick(HP);
      ps2_clk = 1;
    end
    io_rdn = 1;
    ps2_data = 1;
    tick(2);
  endtask

  task automatic frame(input byte unsigned d, input bit bp = 0, input bit bs = 0,
                       input bit bst = 0, input bit rd_sync = 0);
    int sz = q.size();
    bit popped = rd_sync && sz > 0;
    bit ok = !(bp || bs || bst);
    send_bits(mk(d, bp, bs, bst), 11, rd_sync);
    if (popped) begin
      void'(q.pop_front());
      m_ov = 0;
    end
    if (ok) begin
      if (sz < 8 || popped) q.push_back(d);
      else m_ov = 1;
    end
  endtask

  task automatic read(input int hold = 1);
    io_rdn = 0;
    tick(hold);
    io_rdn = 1;
    tick(1);
    if (q.size() > 0) begin
      void'(q.pop_front());
      m_ov = 0;
    end
  endtask

  task automatic expect_state(input string tag);
    check({tag, ".ready"}, 32'(ready), 32'(q.size() > 0));
    check({tag, ".key_data"}, 32'(key_data), q.size() > 0 ? 32'(q[0]) : 32'd0);
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ov));
  endtask

  task automatic do_reset();
    clrn = 0;
    tick(2);
    clrn = 1;
    q.delete();
    m_ov = 0;
    tick(1);
  endtask

  initial begin
    do_reset();
    expect_state("reset");
    frame(8'h1C);
    expect_state("t1_pre");
    check("t1_head", 32'(key_data), 32'h1C);
    read();
    expect_state("t1_post");
    frame(8'hF0, 1);
    expect_state("t2_badpar");
    frame(8'h1C, 0, 1);
    expect_state("t2_badstop");
    for (int i = 1; i <= 9; i++) begin
      frame(8'(i));
      if (i == 8) expect_state("t3_full");
    end
    expect_state("t3_ovf");
    check("t3_ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      read();
      expect_state("t3_drain");
    end
    send_bits(mk(8'h55, 0, 0, 0), 5, 0);
    expect_state("t4_partial");
    tick(2600);
    frame(8'h2A);
    expect_state("t4_after");
    read();
    expect_state("t4_empty");
    for (int i = 1; i <= 8; i++) frame(8'(i));
    frame(8'h09, 0, 0, 0, 1);
    expect_state("t5_sync");
    check("t5_head", 32'(key_data), 32'h02);
    for (int i = 0; i < 8; i++) begin
      read();
      expect_state("t5_drain");
    end
    for (int i = 0; i < 3; i++) frame(8'($urandom_range(0, 255)));
    read(20);
    expect_state("t6_hold");
    send_bits(mk(8'h77, 0, 0, 0), 5, 0);
    clrn = 0;
    #1;
    check("t6_rst_ready", 32'(ready), 32'd0);
    check("t6_rst_data", 32'(key_data), 32'd0);
    check("t6_rst_ovf", 32'(overflow), 32'd0);
    tick(1);
    clrn = 1;
    q.delete();
    m_ov = 0;
    tick(1);
    frame(8'h3B);
    expect_state("t6_after");
    for (int it = 0; it < 60; it++) begin
      int r = $urandom_range(0, 9);
      if (r < 6) begin
        frame(8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      end else if (r < 9) begin
        read($urandom_range(1, 3));
      end else begin
        frame(8'($urandom_range(0, 255)), 0, 0, 0, 1);
      end
      expect_state("rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
